// File: rtl/tdc_phase_decoder.sv
// TDC measurement back-end: decodes start/stop phase snapshots, counts coarse cycles,
// and delivers the start-to-stop interval in T/8 units. Optional macro: TDC_BUBBLE_CORRECT_EN.
module tdc_phase_decoder #(
    parameter int unsigned BIT_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [3:0]           i_phase_start,
    input  logic [3:0]           i_phase_stop,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [BIT_COUNT-1:0] o_interval,
    output logic                 o_error
);

    localparam int unsigned CW = BIT_COUNT - 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   coarse;
    logic [2:0]      fine_start;
    logic            bubble_start;
    logic            ovf;

    // Returns {bubble, fine[2:0]} for a {p135,p90,p45,p0} snapshot.
    function automatic logic [3:0] decode(input logic [3:0] p);
`ifdef TDC_BUBBLE_CORRECT_EN
        logic [2:0] n;
        n = 3'(p[0]) + 3'(p[1]) + 3'(p[2]) + 3'(p[3]);
        if (p[0])
            decode = {1'b0, n - 3'd1};
        else
            decode = {1'b0, 3'd7 - n};
`else
        case (p)
            4'b0001: decode = 4'b0_000;
            4'b0011: decode = 4'b0_001;
            4'b0111: decode = 4'b0_010;
            4'b1111: decode = 4'b0_011;
            4'b1110: decode = 4'b0_100;
            4'b1100: decode = 4'b0_101;
            4'b1000: decode = 4'b0_110;
            4'b0000: decode = 4'b0_111;
            default: decode = 4'b1_000;
        endcase
`endif
    endfunction

    logic [3:0]           dec_start;
    logic [3:0]           dec_stop;
    logic [CW-1:0]        coarse_inc;
    logic                 ovf_inc;
    logic [CW-1:0]        res_coarse;
    logic                 res_ovf;
    logic [2:0]           res_fine_start;
    logic                 res_bubble_start;
    logic [BIT_COUNT:0]   diff;
    logic                 res_neg;
    logic [BIT_COUNT-1:0] res_interval;
    logic                 res_error;

    always_comb begin
        dec_start  = decode(i_phase_start);
        dec_stop   = decode(i_phase_stop);
        coarse_inc = (coarse == '1) ? coarse : coarse + CW'(1);
        ovf_inc    = ovf | (coarse == '1);
        // A stop in the start cycle uses the live start snapshot and coarse=0.
        if (state == IDLE) begin
            res_coarse       = '0;
            res_ovf          = 1'b0;
            res_fine_start   = dec_start[2:0];
            res_bubble_start = dec_start[3];
        end else begin
            res_coarse       = coarse_inc;
            res_ovf          = ovf_inc;
            res_fine_start   = fine_start;
            res_bubble_start = bubble_start;
        end
        diff = {1'b0, res_coarse, 3'b000}
             + (BIT_COUNT+1)'(dec_stop[2:0])
             - (BIT_COUNT+1)'(res_fine_start);
        res_neg = diff[BIT_COUNT];
        if (res_ovf)
            res_interval = '1;
        else if (res_neg)
            res_interval = '0;
        else
            res_interval = diff[BIT_COUNT-1:0];
        res_error = res_bubble_start | dec_stop[3] | res_neg | res_ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            coarse       <= '0;
            fine_start   <= '0;
            bubble_start <= 1'b0;
            ovf          <= 1'b0;
            o_valid      <= 1'b0;
            o_interval   <= '0;
            o_error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        fine_start   <= dec_start[2:0];
                        bubble_start <= dec_start[3];
                        coarse       <= '0;
                        ovf          <= 1'b0;
                        if (i_stop) begin
                            o_valid    <= 1'b1;
                            o_interval <= res_interval;
                            o_error    <= res_error;
                            state      <= DONE;
                        end else begin
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    coarse <= coarse_inc;
                    ovf    <= ovf_inc;
                    if (i_stop) begin
                        o_valid    <= 1'b1;
                        o_interval <= res_interval;
                        o_error    <= res_error;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_phase_decoder.sv
// Scoreboard bench for tdc_phase_decoder: driver pushes expected results, monitor checks
// every cycle o_valid is high and pops on transfer.
module tb_tdc_phase_decoder;

    localparam int unsigned BW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic [3:0]    i_phase_start = 4'b0001;
    logic [3:0]    i_phase_stop = 4'b0001;
    logic          i_ready = 1'b1;
    logic          o_valid;
    logic [BW-1:0] o_interval;
    logic          o_error;

    typedef struct {
        logic [BW-1:0] interval;
        logic          error;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    tdc_phase_decoder #(.BIT_COUNT(BW)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_phase_start (i_phase_start),
        .i_phase_stop  (i_phase_stop),
        .i_ready       (i_ready),
        .o_valid       (o_valid),
        .o_interval    (o_interval),
        .o_error       (o_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs must match the head entry for every valid cycle (held under backpressure).
    always @(negedge clk) begin
        if (!reset && o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                check("interval", int'(o_interval), int'(sb[0].interval));
                check("error", int'(o_error), int'(sb[0].error));
                if (i_ready) void'(sb.pop_front());
            end
        end
    end

    // n = cycles from start to stop; n=0 means both strobes in the same cycle.
    task automatic measure(input logic [3:0] ps, input logic [3:0] pe, input int n,
                           input logic [BW-1:0] ei, input logic ee);
        exp_t e;
        e.interval = ei;
        e.error    = ee;
        sb.push_back(e);
        i_start       = 1'b1;
        i_phase_start = ps;
        if (n == 0) begin
            i_stop       = 1'b1;
            i_phase_stop = pe;
        end
        step();
        i_start = 1'b0;
        i_phase_start = 4'b1010;
        if (n > 0) begin
            repeat (n - 1) step();
            check("no_early_valid", int'(o_valid), 0);
            i_stop       = 1'b1;
            i_phase_stop = pe;
            step();
        end
        i_stop = 1'b0;
        i_phase_stop = 4'b0101;
        check("valid_latency", int'(o_valid), 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || o_valid) && k < 50) begin
            step();
            k++;
        end
        check("drain_timeout", int'(k >= 50), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        check("reset_valid", int'(o_valid), 0);
        check("reset_interval", int'(o_interval), 0);
        check("reset_error", int'(o_error), 0);
        reset = 1'b0;
        step();

        // Nominal: 5*8 + 2 - 0
        measure(4'b0001, 4'b0111, 5, 8'd42, 1'b0);
        drain();
        // Same-cycle start/stop: 4 - 1
        measure(4'b0011, 4'b1110, 0, 8'd3, 1'b0);
        drain();
        // Same-cycle, negative: 1 - 4 clamps to 0
        measure(4'b1110, 4'b0011, 0, 8'd0, 1'b1);
        drain();
        // Large coarse without saturation: 30*8 + 3 - 0
        measure(4'b0001, 4'b1111, 30, 8'd243, 1'b0);
        drain();
        // Sector-7 stop: 1*8 + 7 - 6
        measure(4'b1000, 4'b0000, 1, 8'd9, 1'b0);
        drain();

        // Backpressure with ignored strobes: 3*8 + 5 - 1
        i_ready = 1'b0;
        measure(4'b0011, 4'b1100, 3, 8'd28, 1'b0);
        for (int i = 0; i < 10; i++) begin
            i_start       = (i % 3 == 0);
            i_stop        = (i % 3 == 1);
            i_phase_start = 4'b1111;
            i_phase_stop  = 4'b0000;
            step();
        end
        i_start = 1'b0;
        i_stop  = 1'b0;
        check("bp_held_valid", int'(o_valid), 1);
        i_ready = 1'b1;
        step();
        check("bp_single_transfer", int'(o_valid), 0);
        repeat (5) step();
        check("bp_queue_empty", sb.size(), 0);

        // Bubble on stop snapshot 0101
`ifdef TDC_BUBBLE_CORRECT_EN
        measure(4'b0001, 4'b0101, 2, 8'd17, 1'b0);
`else
        measure(4'b0001, 4'b0101, 2, 8'd16, 1'b1);
`endif
        drain();
        // Bubble on start snapshot 1010: 1*8 + 3 - fine_start
`ifdef TDC_BUBBLE_CORRECT_EN
        measure(4'b1010, 4'b1111, 1, 8'd6, 1'b0);
`else
        measure(4'b1010, 4'b1111, 1, 8'd11, 1'b1);
`endif
        drain();

        // Coarse overflow with 5-bit counter
        measure(4'b0001, 4'b0001, 40, 8'hFF, 1'b1);
        drain();

        // Reset mid-RUN, then fresh measurement
        i_start       = 1'b1;
        i_phase_start = 4'b0001;
        step();
        i_start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_run_valid", int'(o_valid), 0);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        check("stray_stop_idle", int'(o_valid), 0);
        measure(4'b0001, 4'b0001, 1, 8'd8, 1'b0);
        drain();

        // Reset while DONE discards the held result
        i_ready = 1'b0;
        measure(4'b0001, 4'b0011, 2, 8'd17, 1'b0);
        step();
        reset = 1'b1;
        #1;
        check("reset_done_valid", int'(o_valid), 0);
        check("reset_done_interval", int'(o_interval), 0);
        sb.delete();
        step();
        reset   = 1'b0;
        i_ready = 1'b1;
        repeat (3) step();
        check("final_queue_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdc_phase_decoder.md
# tdc_phase_decoder

Measurement back-end of the TDC quadrature chain. Takes 4-bit snapshots of the four 45°-spaced phases of the quadrature clock, captured at a start event and at a stop event, and decodes each into a 3-bit fine code. It counts coarse `clk` cycles between the two events and delivers a start-to-stop interval in units of T/8 over a valid/ready handshake. It sits downstream of the quadrature clock generator and the phase-capture flops, and upstream of the DAQ result FIFO.

## Interface
- `BIT_COUNT`, 32: width of `o_interval`; the coarse counter is `BIT_COUNT-3` bits.
- `clk` in 1: system clock; phase 0 of the quadrature set.
- `reset` in 1: asynchronous, active-high.
- `i_start` in 1: start strobe, one cycle, synchronous to `clk`.
- `i_stop` in 1: stop strobe, one cycle, synchronous to `clk`.
- `i_phase_start` in 4: captured phases at start, `{p135,p90,p45,p0}`; valid with `i_start`.
- `i_phase_stop` in 4: captured phases at stop, same order; valid with `i_stop`.
- `i_ready` in 1: downstream accepts the result.
- `o_valid` out 1: result available.
- `o_interval` out `BIT_COUNT`: measured interval in T/8 units.
- `o_error` out 1: result unreliable; qualified by `o_valid`.

## Operation
- Fine decode, pattern `{p135,p90,p45,p0}` to sector:
  - 0001→0, 0011→1, 0111→2, 1111→3
  - 1110→4, 1100→5, 1000→6, 0000→7
  - Any other pattern is a bubble. Without the macro, a bubble gives fine=0 and sets the error.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On `i_start`, latch `fine_start`, clear coarse and the error flags, then go to RUN.
  - If `i_stop` is high in the same cycle, go straight to DONE with coarse=0.
- RUN:
  - coarse increments by 1 each cycle and saturates at all-ones, which sets the overflow flag.
  - `i_start` is ignored.
  - On `i_stop`, latch `fine_stop`, compute the result, then go to DONE.
- DONE:
  - `o_valid`=1 and the outputs are held stable.
  - `i_start` and `i_stop` are ignored; the strobes are not queued.
  - When `o_valid && i_ready`, go to IDLE.
- Arithmetic:
  - Compute `{coarse,3'b000} + fine_stop − fine_start` in `BIT_COUNT+1` signed bits.
  - A negative result clamps to 0 and sets the error.
  - On overflow, the result is all-ones and the error is set.
- `o_error` = bubble on either snapshot OR negative result OR overflow.

## Timing
- Reset values: state IDLE, `o_valid`=0, `o_interval`=0, `o_error`=0, coarse=0.
- Coarse counts the `clk` cycles from the `i_start` cycle to the `i_stop` cycle. A stop N cycles after start gives coarse=N.
- `o_valid` rises on the first edge after the cycle that samples `i_stop`, a latency of 1 cycle. `o_interval` and `o_error` are registered on that same edge.
- Handshake:
  - The result is consumed on the edge where `o_valid && i_ready`; `o_valid` drops on that edge.
  - A new `i_start` is accepted from the following cycle.
  - `i_ready` may be held high permanently.
- Reset asserted mid-measurement or in DONE discards the result immediately. No partial output is produced.

## Configuration
- `TDC_BUBBLE_CORRECT_EN` defined: bubbles are corrected by population count.
  - With n = number of ones in the snapshot: if p0=1, fine = n−1; else fine = 7−n.
  - Bubbles do not contribute to `o_error`.
- `TDC_BUBBLE_CORRECT_EN` not defined: strict table decode.
  - A bubble forces that fine code to 0 and sets `o_error`.

## Test plan
- Nominal: start with phase 0001, stop 5 cycles later with phase 0111, `i_ready`=1 → `o_valid` one cycle after stop, `o_interval`=42, `o_error`=0.
- Simultaneous start and stop in IDLE, start phase 0011, stop phase 1110 → `o_interval`=3. Variant with start 1110 and stop 0011 → negative, `o_interval`=0, `o_error`=1.
- Backpressure: `i_ready`=0 for 10 cycles after valid, extra `i_start` and `i_stop` pulses during DONE → outputs held, pulses ignored, one transfer when `i_ready`=1.
- Bubble: stop phase 0101, start 0001, coarse 2, i.e. stop 2 cycles after start:
  - Macro off: `o_interval`=16, `o_error`=1.
  - Macro on: fine=1 (p0=1, n=2), `o_interval`=17, `o_error`=0.
- Overflow: `BIT_COUNT`=8 (coarse 5 bits), stop 40 cycles after start → `o_interval`=8'hFF, `o_error`=1.
- Reset mid-RUN at cycle 3, then a fresh start with phase 0001 and a stop 1 cycle later with phase 0001 → no output before the new stop, then `o_interval`=8.
